// File: rtl/alu8_pkg.sv
// Shared opcode, state and helper definitions
// for the two-requester alu8 sequencer.
package alu8_pkg;

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_ASL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    unique case (op)
      OP_AND, OP_OR, OP_XOR,
      OP_ADD, OP_SUB, OP_NOT,
      OP_LSL, OP_LSR, OP_ASL: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer
// moves past the winner on each accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  always_comb begin
    grant_id = ptr;
    if (!valid[ptr])
      grant_id = ~ptr;
    grant = 2'b00;
    if (valid[grant_id])
      grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= 1'b0;
    else if (accept)
      ptr <= ~grant_id;
  end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one alu8 between two issuers: grant,
// issue, wait fixed latency, return tagged result.
module alu8_arbiter
  import alu8_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_op_code,
  input  logic [2*DATA_W-1:0] req_operand_1,
  input  logic [2*DATA_W-1:0] req_operand_2,
  input  logic [5:0]        req_shift_rotate,
  output logic [3:0]        alu_op_code,
  output logic [DATA_W-1:0] alu_operand_1,
  output logic [DATA_W-1:0] alu_operand_2,
  output logic [2:0]        alu_shift_rotate,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_error,
  output logic              busy
);

  localparam logic [2:0] LAT_M1 =
    3'(ALU_LATENCY - 1);

  state_t state;
  state_t state_nx;

  logic [2:0]        cnt;
  logic [1:0]        grant;
  logic              gid;
  logic              accept;
  logic              legal;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [2:0]        sel_sh;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .valid    (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (gid)
  );

  always_comb begin
    sel_op = gid ? req_op_code[7:4]
                 : req_op_code[3:0];
    sel_a  = gid ? req_operand_1[2*DATA_W-1:DATA_W]
                 : req_operand_1[DATA_W-1:0];
    sel_b  = gid ? req_operand_2[2*DATA_W-1:DATA_W]
                 : req_operand_2[DATA_W-1:0];
    sel_sh = gid ? req_shift_rotate[5:3]
                 : req_shift_rotate[2:0];
  end

  assign legal = is_legal_op(sel_op);

  // Ready is combinational; keep it low while reset is held.
  assign req_ready =
    (state == ST_IDLE && reset) ? grant : 2'b00;

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          accept   = 1'b1;
          state_nx = legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (cnt == 3'd0)
          state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cnt              <= 3'd0;
      alu_op_code      <= '0;
      alu_operand_1    <= '0;
      alu_operand_2    <= '0;
      alu_shift_rotate <= '0;
      rsp_id           <= 1'b0;
      rsp_result       <= '0;
      rsp_carry        <= 1'b0;
      rsp_error        <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= gid;
            if (legal) begin
              alu_op_code      <= sel_op;
              alu_operand_1    <= sel_a;
              alu_operand_2    <= sel_b;
              alu_shift_rotate <= sel_sh;
            end else begin
              rsp_error  <= 1'b1;
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
            end
          end
        end
        ST_ISSUE: cnt <= LAT_M1;
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_error  <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_arbiter.sv
// Directed bench for alu8_arbiter with
// pipelined alu8 models at latency 1 and 3.
module tb_alu8_arbiter;
  import alu8_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  initial forever #5 clk = ~clk;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_op_code = '0;
  logic [15:0] req_operand_1 = '0;
  logic [15:0] req_operand_2 = '0;
  logic [5:0]  req_shift_rotate = '0;
  logic [3:0]  alu_op_code;
  logic [7:0]  alu_operand_1;
  logic [7:0]  alu_operand_2;
  logic [2:0]  alu_shift_rotate;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_error;
  logic        busy;

  logic [1:0]  b_req_valid = '0;
  logic [1:0]  b_req_ready;
  logic [7:0]  b_req_op_code = '0;
  logic [15:0] b_req_operand_1 = '0;
  logic [15:0] b_req_operand_2 = '0;
  logic [5:0]  b_req_shift_rotate = '0;
  logic [3:0]  b_alu_op_code;
  logic [7:0]  b_alu_operand_1;
  logic [7:0]  b_alu_operand_2;
  logic [2:0]  b_alu_shift_rotate;
  logic [7:0]  b_alu_result;
  logic        b_alu_carry;
  logic        b_rsp_valid;
  logic        b_rsp_id;
  logic [7:0]  b_rsp_result;
  logic        b_rsp_carry;
  logic        b_rsp_error;
  logic        b_busy;

  int n_chk = 0;
  int n_fail = 0;
  int n;

  alu8_arbiter #(.ALU_LATENCY(1)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_code(req_op_code),
    .req_operand_1(req_operand_1),
    .req_operand_2(req_operand_2),
    .req_shift_rotate(req_shift_rotate),
    .alu_op_code(alu_op_code),
    .alu_operand_1(alu_operand_1),
    .alu_operand_2(alu_operand_2),
    .alu_shift_rotate(alu_shift_rotate),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_error(rsp_error),
    .busy(busy)
  );

  alu8_arbiter #(.ALU_LATENCY(3)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op_code(b_req_op_code),
    .req_operand_1(b_req_operand_1),
    .req_operand_2(b_req_operand_2),
    .req_shift_rotate(b_req_shift_rotate),
    .alu_op_code(b_alu_op_code),
    .alu_operand_1(b_alu_operand_1),
    .alu_operand_2(b_alu_operand_2),
    .alu_shift_rotate(b_alu_shift_rotate),
    .alu_result(b_alu_result), .alu_carry(b_alu_carry),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
    .rsp_id(b_rsp_id), .rsp_result(b_rsp_result),
    .rsp_carry(b_rsp_carry), .rsp_error(b_rsp_error),
    .busy(b_busy)
  );

  // Bench ALU: ADD carry = signed overflow, SUB carry = borrow.
  function automatic logic [8:0] alu_f(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] sh
  );
    logic [7:0] r;
    logic c;
    r = 8'h00;
    c = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: begin
        r = 8'(a + b);
        c = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        r = 8'(a - b);
        c = (a < b);
      end
      OP_NOT: r = ~a;
      OP_LSL: r = a << sh;
      OP_LSR: r = a >> sh;
      OP_ASL: r = a << sh;
      default: ;
    endcase
    return {c, r};
  endfunction

  logic [8:0] a_p1;
  logic [8:0] b_p1, b_p2, b_p3;

  always_ff @(posedge clk) begin
    a_p1 <= alu_f(alu_op_code, alu_operand_1,
                  alu_operand_2, alu_shift_rotate);
    b_p1 <= alu_f(b_alu_op_code, b_alu_operand_1,
                  b_alu_operand_2, b_alu_shift_rotate);
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end

  assign {alu_carry, alu_result}     = a_p1;
  assign {b_alu_carry, b_alu_result} = b_p3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!rsp_valid && cyc < 20);
    chk("rsp_timeout", 16'(rsp_valid), 16'd1);
  endtask

  initial begin
    req_valid = 2'b11;
    #2;
    chk("rst_ready", 16'(req_ready), 16'd0);
    step();
    chk("rst_alu", {alu_op_code, alu_operand_1,
        alu_shift_rotate, 1'b0}, 16'h0000);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_carry,
        rsp_error, busy, 3'b0, rsp_result}, 16'h0000);
    req_valid = 2'b00;
    reset = 1'b1;

    // single ADD from requester 0
    req_valid = 2'b01;
    req_op_code = {4'h0, OP_ADD};
    req_operand_1 = 16'h003C;
    req_operand_2 = 16'h0050;
    #1;
    chk("t1_ready", 16'(req_ready), 16'd1);
    step();
    chk("t1_issue", {busy, rsp_valid, req_ready,
        alu_op_code, alu_operand_1}, 16'h853C);
    chk("t1_opnd2", 16'(alu_operand_2), 16'h0050);
    req_valid = 2'b00;
    step();
    chk("t1_e1", 16'(rsp_valid), 16'd0);
    step();
    chk("t1_valid", 16'(rsp_valid), 16'd1);
    chk("t1_rsp", {rsp_id, rsp_carry, rsp_error,
        5'b0, rsp_result}, 16'h408C);
    rsp_ready = 1'b1;
    step();
    chk("t1_done", {14'b0, rsp_valid, busy}, 16'd0);

    // dual requests from a fresh pointer
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_valid = 2'b11;
    req_op_code = {OP_SUB, OP_AND};
    req_operand_1 = 16'h10F0;
    req_operand_2 = 16'h203C;
    #1;
    chk("t2_ready0", 16'(req_ready), 16'd1);
    wait_rsp(n);
    chk("t2_lat0", 16'(n), 16'd3);
    chk("t2_rsp0", {rsp_id, rsp_carry, rsp_error,
        5'b0, rsp_result}, 16'h0030);
    step();
    chk("t2_ready1", 16'(req_ready), 16'd2);
    wait_rsp(n);
    chk("t2_lat1", 16'(n), 16'd3);
    chk("t2_rsp1", {rsp_id, rsp_carry, rsp_error,
        5'b0, rsp_result}, 16'hC0F0);
    wait_rsp(n);
    chk("t2_spacing", 16'(n), 16'd4);
    chk("t2_rsp2", {rsp_id, rsp_carry, rsp_error,
        5'b0, rsp_result}, 16'h0030);
    req_valid = 2'b00;

    // illegal opcode from requester 1
    step();
    req_valid = 2'b10;
    req_op_code = {4'b0100, 4'h0};
    req_operand_1 = 16'hAA00;
    req_operand_2 = 16'h5500;
    #1;
    chk("t3_ready", 16'(req_ready), 16'd2);
    step();
    chk("t3_rsp", {rsp_valid, rsp_id, rsp_carry,
        rsp_error, 4'b0, rsp_result}, 16'hD000);
    chk("t3_alu", {alu_op_code, alu_operand_1,
        4'b0}, 16'h1F00);
    chk("t3_opnd2", 16'(alu_operand_2), 16'h003C);
    req_valid = 2'b00;
    step();
    chk("t3_done", {14'b0, rsp_valid, busy}, 16'd0);

    // response stall with a pending request
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_op_code = {4'h0, OP_OR};
    req_operand_1 = 16'h000F;
    req_operand_2 = 16'h0030;
    wait_rsp(n);
    chk("t4_lat", 16'(n), 16'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_stall", {rsp_valid, req_ready, rsp_id,
          rsp_carry, rsp_error, 2'b0, rsp_result},
          16'h803F);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_release", {busy, rsp_valid, 12'b0,
        req_ready}, 16'h0001);
    wait_rsp(n);
    chk("t4_lat2", 16'(n), 16'd3);
    chk("t4_rsp2", 16'(rsp_result), 16'h003F);
    req_valid = 2'b00;

    // reset while waiting on the ALU
    step();
    req_valid = 2'b01;
    req_op_code = {4'h0, OP_XOR};
    req_operand_1 = 16'h00FF;
    req_operand_2 = 16'h000F;
    step();
    req_valid = 2'b00;
    step();
    chk("t5_wait", 16'(busy), 16'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_alu", {alu_op_code, alu_operand_1,
        alu_shift_rotate, 1'b0}, 16'h0000);
    chk("t5_rst_rsp", {rsp_valid, rsp_id, rsp_carry,
        rsp_error, busy, 3'b0, rsp_result}, 16'h0000);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("t5_norsp", {14'b0, rsp_valid, busy}, 16'd0);
    req_valid = 2'b10;
    req_op_code = {OP_LSL, 4'h0};
    req_operand_1 = 16'h8100;
    req_operand_2 = 16'h0000;
    req_shift_rotate = 6'b001_000;
    wait_rsp(n);
    chk("t5_lat", 16'(n), 16'd3);
    chk("t5_rsp", {rsp_id, rsp_carry, rsp_error,
        5'b0, rsp_result}, 16'h8002);
    chk("t5_shift", 16'(alu_shift_rotate), 16'd1);
    req_valid = 2'b00;

    // latency-3 instance
    b_req_valid = 2'b01;
    b_req_op_code = {4'h0, OP_SUB};
    b_req_operand_1 = 16'h0005;
    b_req_operand_2 = 16'h0007;
    #1;
    chk("t6_ready", 16'(b_req_ready), 16'd1);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) b_req_valid = 2'b00;
    end while (!b_rsp_valid && n < 20);
    chk("t6_lat", 16'(n), 16'd5);
    chk("t6_rsp", {b_rsp_valid, b_rsp_id, b_rsp_carry,
        b_rsp_error, 4'b0, b_rsp_result}, 16'hA0FE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu8_arbiter.md
Name: alu8_arbiter

Overview:
Round-robin arbiter and sequencer that shares one alu8 datapath between two requesters. Accepts one ALU operation per grant over a valid/ready handshake and drives the ALU operand/opcode inputs from registers. Waits the ALU's fixed result latency, captures result and carry, and returns them on a tagged response channel. Sits between instruction-issue logic (two independent issuers) and the single alu8 instance.

Parameters:
ALU_LATENCY, 1, clock edges from ALU input sampling to valid ALU result; legal range 1..7
DATA_W, 8, operand/result width; fixed by the ALU, not to be overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: operation from requester i accepted this cycle
req_op_code  input  8  [4i+3:4i] opcode of requester i
req_operand_1  input  16  [8i+7:8i] operand_1 of requester i
req_operand_2  input  16  [8i+7:8i] operand_2 of requester i
req_shift_rotate  input  6  [3i+2:3i] shift/rotate amount of requester i
alu_op_code  output  4  to ALU op_code, registered
alu_operand_1  output  8  to ALU operand_1, registered
alu_operand_2  output  8  to ALU operand_2, registered
alu_shift_rotate  output  3  to ALU shift_rotate, registered
alu_result  input  8  from ALU result
alu_carry  input  1  from ALU carry
rsp_valid  output  1  response held valid
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester index of the response
rsp_result  output  8  captured ALU result
rsp_carry  output  1  captured ALU carry
rsp_error  output  1  operation rejected (illegal opcode)
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=0, all alu_* = 0, rsp_valid/rsp_id/rsp_result/rsp_carry/rsp_error = 0, req_ready=0, wait counter=0. Reset mid-operation drops the in-flight op; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = pointer requester if its req_valid, else the other if valid. req_ready[grant]=1 combinationally, only in IDLE, at most one bit set. On an accepting edge: latch fields into alu_* registers, store grant as rsp_id, pointer := ~grant. Legal opcode -> ISSUE; illegal opcode -> RESP with rsp_error=1, rsp_result=0, rsp_carry=0, alu_* left unchanged (ALU not issued).
- Legal opcodes: 0001, 0010, 0011, 0101, 0110, 0111, 1000, 1001, 1010. All others are illegal.
- ISSUE: exactly 1 cycle; ALU samples alu_* at its end. Load counter=ALU_LATENCY-1; go WAIT.
- WAIT: if counter==0, capture alu_result/alu_carry into rsp_result/rsp_carry, rsp_error=0, go RESP; else decrement.
- RESP: rsp_valid=1, all rsp_* stable. On rsp_valid&rsp_ready edge: rsp_valid=0, go IDLE. Stall on rsp_ready is unbounded.
- Latency: acceptance edge E -> rsp_valid high after edge E+1+ALU_LATENCY. Minimum op-to-op spacing with rsp_ready tied high is ALU_LATENCY+3 cycles.
- alu_* hold the last issued values between operations.
- Requester rules: payload stable while req_valid=1 and req_ready=0. Dropping req_valid before acceptance is permitted; the request is simply not served.
- Simultaneous valid: the pointer requester wins, and the loser is granted next. Continuous dual requests alternate 0,1,0,1.
- No new request is accepted while not IDLE, including in RESP.

Decomposition:
- alu8_pkg: opcode localparams (OP_AND=0001 ... OP_ASL=1010), state enum type, is_legal_op function.
- Sub-module rr_arbiter2: 2-way round-robin grant with pointer update on accept. The FSM, counter and registers stay in alu8_arbiter.

Test Plan:
- Reset, then req0: op 0101, 0x3C, 0x50 -> rsp_valid after edge E+2 (ALU_LATENCY=1), rsp_id=0, rsp_result=0x8C, rsp_carry=1, rsp_error=0.
- req0 and req1 both valid from reset (req0 AND 0xF0&0x3C, req1 SUB 0x10-0x20) -> responses in order id0 0x30 carry0, then id1 0xF0 carry1. A third round grants req0 again.
- req1 op 0100 -> no ALU input change, rsp_error=1, rsp_result=0, response after edge E+1.
- rsp_ready held low 10 cycles during RESP with req0 valid -> rsp_* stable, req_ready stays 0. After release, req0 is accepted in the next IDLE cycle.
- Assert reset in WAIT -> all outputs zero immediately, no response emitted. After deassert, req1 op 1000, 0x81, shift 1 -> rsp_result=0x02, rsp_carry=0.
- ALU_LATENCY=3 build with an ALU model delayed to match -> rsp_valid after edge E+4, correct result captured.
